main_memory_ctrl: RTL and testbench

Word-granular main-memory controller that sits directly downstream of the L2 cache and services its miss requests (`mem_req` / `mem_addr` → `mem_ready` / `mem_read_data`). It also accepts word writes, which are the path for the planned L2 dirty-line writeback. Requests are captured into a small FIFO, serviced one at a time with a programmable access latency, and completed with a single-cycle `mem_ready` pulse.

---
 rtl/main_memory_ctrl_if.sv | 22 ++
 rtl/main_memory_ctrl.sv | 132 +++++++++++++
 tb/tb_main_memory_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/main_memory_ctrl_if.sv
// Request/completion bus between the L2 cache (master) and the main-memory
// controller (slave).
interface main_memory_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic [31:0] mem_read_data;
  logic        busy;
  logic        req_overflow;

  modport master (
    output mem_req, mem_we, mem_addr, mem_write_data,
    input  mem_ready, mem_read_data, busy, req_overflow
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_write_data,
    output mem_ready, mem_read_data, busy, req_overflow
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Word-granular main memory behind the L2 cache: queues requests in a small FIFO
// and services them one at a time with a fixed access latency.
module main_memory_ctrl #(
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = 8,
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  main_memory_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_actWe;
  logic [IDX_W-1:0]   r_actIdx;
  logic [31:0]        r_actData;
  logic               r_ready;
  logic [31:0]        r_readData;
  logic               r_overflow;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;

  logic               r_fifoWe   [FIFO_DEPTH];
  logic [IDX_W-1:0]   r_fifoIdx  [FIFO_DEPTH];
  logic [31:0]        r_fifoData [FIFO_DEPTH];

  logic [31:0]        r_mem [MEM_WORDS];
  // A word never written reads back its own index, which gives the
  // "word i holds i" power-up contents without an initialisation pass.
  logic [MEM_WORDS-1:0] r_written = '0;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_commit;
  logic [IDX_W-1:0]   w_reqIdx;
  logic [31:0]        w_readWord;
  logic               w_unusedAddr;

  assign w_reqIdx     = bus.mem_addr[2 +: IDX_W];
  assign w_unusedAddr = ^{bus.mem_addr[1:0], bus.mem_addr[31:2+IDX_W]};

  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[PTR_W-1] != r_rdPtr[PTR_W-1]) &&
                   (r_wrPtr[PTR_W-2:0] == r_rdPtr[PTR_W-2:0]);
  assign w_pop   = (r_state == IDLE) && !w_empty;
  assign w_push  = bus.mem_req && (!w_full || w_pop);

  assign w_commit   = (r_state == ACCESS) && (r_cnt == '0) && r_actWe;
  assign w_readWord = r_written[r_actIdx] ? r_mem[r_actIdx] : 32'(r_actIdx);

  assign bus.mem_ready     = r_ready;
  assign bus.mem_read_data = r_readData;
  assign bus.req_overflow  = r_overflow;
  assign bus.busy          = (r_state != IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoWe[r_wrPtr[PTR_W-2:0]]   <= bus.mem_we;
      r_fifoIdx[r_wrPtr[PTR_W-2:0]]  <= w_reqIdx;
      r_fifoData[r_wrPtr[PTR_W-2:0]] <= bus.mem_write_data;
    end
  end

  // Commit depends on the reset FSM state, so a reset before the commit edge
  // leaves the array untouched.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_actIdx]     <= r_actData;
      r_written[r_actIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_actWe    <= 1'b0;
      r_actIdx   <= '0;
      r_actData  <= '0;
      r_ready    <= 1'b0;
      r_readData <= '0;
      r_overflow <= 1'b0;
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (bus.mem_req && !w_push) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_actWe   <= r_fifoWe[r_rdPtr[PTR_W-2:0]];
            r_actIdx  <= r_fifoIdx[r_rdPtr[PTR_W-2:0]];
            r_actData <= r_fifoData[r_rdPtr[PTR_W-2:0]];
            r_rdPtr   <= r_rdPtr + 1'b1;
            r_cnt     <= CNT_W'(LATENCY - 1);
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_readData <= r_actWe ? r_actData : w_readWord;
            r_ready    <= 1'b1;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl: stimulus pushes expected completions into
// a scoreboard that a negedge monitor pops on every mem_ready pulse.
module tb_main_memory_ctrl;
  localparam int LATENCY = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_memory_ctrl_if bus();

  main_memory_ctrl #(
    .MEM_WORDS(4096),
    .LATENCY(LATENCY),
    .FIFO_DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    int          readyCyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        prevReady = 1'b0;
  logic [31:0] lastData = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // delay = cycles from issue to the negedge that sees mem_ready; 0 = unchecked
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input bit expectResp, input logic [31:0] expData, input int delay);
    exp_t e;
    bus.mem_req        = 1'b1;
    bus.mem_we         = we;
    bus.mem_addr       = addr;
    bus.mem_write_data = wdata;
    if (expectResp) begin
      e.data     = expData;
      e.readyCyc = (delay == 0) ? -1 : cyc + delay;
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic dropReq();
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
  endtask

  task automatic waitIdle(input int bound, input string name);
    bit done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (!bus.busy && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prevReady = 1'b0;
      lastData  = bus.mem_read_data;
    end else begin
      if (bus.mem_ready) begin
        checkOutput("readyNotBackToBack", 32'(prevReady), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedReady: got pulse with data 0x%08h, expected none (cycle %0d)",
                   bus.mem_read_data, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("readData", bus.mem_read_data, e.data);
          if (e.readyCyc >= 0) checkOutput("readyCycle", 32'(cyc), 32'(e.readyCyc));
        end
      end else if (bus.mem_read_data !== lastData) begin
        checkOutput("readDataHeld", bus.mem_read_data, lastData);
      end
      prevReady = bus.mem_ready;
      lastData  = bus.mem_read_data;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    bus.mem_req        = 1'b0;
    bus.mem_we         = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_write_data = '0;

    rst = 1'b1;
    repeat (3) tick();
    checkOutput("resetReady", 32'(bus.mem_ready), 32'd0);
    checkOutput("resetData", bus.mem_read_data, 32'd0);
    checkOutput("resetBusy", 32'(bus.busy), 32'd0);
    checkOutput("resetOverflow", 32'(bus.req_overflow), 32'd0);
    rst = 1'b0;
    tick();

    applyStimulus(1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h4, LATENCY + 2);
    dropReq();
    waitIdle(40, "drainFirstRead");

    applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, LATENCY + 2);
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, 1'b1, 32'hDEAD_BEEF, 2 * LATENCY + 3);
    dropReq();
    waitIdle(60, "drainWriteRead");

    applyStimulus(1'b0, 32'h0000_4003, 32'h0, 1'b1, 32'h0, LATENCY + 2);
    dropReq();
    waitIdle(40, "drainWrapLow");
    applyStimulus(1'b0, 32'hFFFF_C008, 32'h0, 1'b1, 32'h2, LATENCY + 2);
    dropReq();
    waitIdle(40, "drainWrapHigh");
    checkOutput("noOverflowYet", 32'(bus.req_overflow), 32'd0);

    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0, LATENCY + 2);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h1, 2 * LATENCY + 3);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0, 1'b1, 32'h2, 3 * LATENCY + 4);
    applyStimulus(1'b0, 32'h0000_000C, 32'h0, 1'b0, 32'h0, 0);
    dropReq();
    checkOutput("overflowSet", 32'(bus.req_overflow), 32'd1);
    waitIdle(100, "drainOverflow");
    checkOutput("overflowSticky", 32'(bus.req_overflow), 32'd1);

    applyStimulus(1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0, 0);
    dropReq();
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    checkOutput("midResetBusy", 32'(bus.busy), 32'd0);
    checkOutput("midResetOverflow", 32'(bus.req_overflow), 32'd0);
    rst = 1'b0;
    tick();
    applyStimulus(1'b0, 32'h0000_0020, 32'h0, 1'b1, 32'h8, LATENCY + 2);
    dropReq();
    waitIdle(40, "drainAfterReset");

    seen = 1'b0;
    applyStimulus(1'b0, 32'h0001_8040, 32'h0, 1'b1, 32'h10, LATENCY + 2);
    dropReq();
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_ready) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("l2ReadySeen", 32'(seen), 32'd1);
    repeat (2) tick();
    checkOutput("l2BusyLow", 32'(bus.busy), 32'd0);
    waitIdle(20, "drainL2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
